// File: rtl/top_idct_div_sdiv_29s_15ns_16_seq.sv
// Sequential signed-by-unsigned restoring divider for the inverse-DCT path.
// Divides a 29-bit signed scaled coefficient by a 15-bit unsigned scale
// factor. It produces one quotient bit per cycle and saturates the result
// to a 16-bit signed sample.
// Optional build macro: TOP_IDCT_DIV_ROUND_NEAREST_EN selects
// round-to-nearest (ties away from zero) in FIX instead of truncation.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for operands; in_ready=1
// CALC  | one restoring-division iteration per cycle, MSB first
// FIX   | apply signs, rounding and saturation; register the outputs
// DONE  | result held with out_valid=1 until out_ready
module top_idct_div_sdiv_29s_15ns_16_seq #(
   parameter int DIVIDEND_WIDTH = 29,
   parameter int DIVISOR_WIDTH  = 15,
   parameter int QUOTIENT_WIDTH = 16
) (
   input  logic                      ap_clk,
   input  logic                      ap_rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DIVIDEND_WIDTH-1:0] dividend,
   input  logic [DIVISOR_WIDTH-1:0]  divisor,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [QUOTIENT_WIDTH-1:0] quotient,
   output logic [DIVISOR_WIDTH:0]    remainder,
   output logic                      overflow,
   output logic                      div_by_zero
);

   localparam int DW    = DIVIDEND_WIDTH;
   localparam int SW    = DIVISOR_WIDTH;
   localparam int QW    = QUOTIENT_WIDTH;
   localparam int CNT_W = $clog2(DW);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DW - 1);
   // Largest positive and negative quotient magnitudes that fit QW signed bits.
   localparam logic [DW:0]      POS_LIM  = {{(DW-QW+2){1'b0}}, {(QW-1){1'b1}}};
   localparam logic [DW:0]      NEG_LIM  = {{(DW-QW+1){1'b0}}, 1'b1, {(QW-1){1'b0}}};
   localparam logic [QW-1:0]    Q_MAX    = {1'b0, {(QW-1){1'b1}}};
   localparam logic [QW-1:0]    Q_MIN    = {1'b1, {(QW-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   // mag_q starts as |dividend| and is shifted left each iteration. The
   // quotient bits enter at the LSB, so it holds the quotient magnitude
   // once CALC is finished.
   logic [DW-1:0]   mag_q, mag_d;
   logic            neg_q, neg_d;
   logic [SW-1:0]   dvs_q, dvs_d;
   logic            dbz_q, dbz_d;
   logic [SW:0]     prem_q, prem_d;
   logic [QW-1:0]   quo_q, quo_d;
   logic [SW:0]     rem_q, rem_d;
   logic            ovf_q, ovf_d;
   logic            dbzo_q, dbzo_d;

   logic [SW:0]     prem_shift;
   logic            prem_ge;
   logic [SW:0]     prem_sub;

   logic [DW:0]     fix_qmag;
   logic [SW:0]     fix_rmag;
   logic            fix_sat;
   logic [QW-1:0]   fix_quo;
   logic [SW:0]     fix_rem;

   // One restoring-division step: shift in the next magnitude bit, then try the subtract.
   always_comb begin
      prem_shift = {prem_q[SW-1:0], mag_q[DW-1]};
      prem_ge    = (prem_shift >= {1'b0, dvs_q});
      prem_sub   = prem_shift - {1'b0, dvs_q};
   end

   // Sign application, optional rounding and saturation used in FIX.
   always_comb begin
      fix_qmag = {1'b0, mag_q};
      fix_rmag = prem_q;
`ifdef TOP_IDCT_DIV_ROUND_NEAREST_EN
      // Round half away from zero. The corrected remainder magnitude
      // becomes rem - divisor, which is negative, so the remainder sign
      // can flip relative to the dividend.
      if ({prem_q, 1'b0} >= {2'b00, dvs_q}) begin
         fix_qmag = fix_qmag + {{DW{1'b0}}, 1'b1};
         fix_rmag = prem_q - {1'b0, dvs_q};
      end
`endif
      fix_sat = neg_q ? (fix_qmag > NEG_LIM) : (fix_qmag > POS_LIM);
      fix_quo = neg_q ? -fix_qmag[QW-1:0] : fix_qmag[QW-1:0];
      fix_rem = neg_q ? -fix_rmag : fix_rmag;
   end

   // Next-state and datapath update.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mag_d   = mag_q;
      neg_d   = neg_q;
      dvs_d   = dvs_q;
      dbz_d   = dbz_q;
      prem_d  = prem_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      ovf_d   = ovf_q;
      dbzo_d  = dbzo_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               neg_d   = dividend[DW-1];
               mag_d   = dividend[DW-1] ? -dividend : dividend;
               dvs_d   = divisor;
               dbz_d   = (divisor == '0);
               cnt_d   = '0;
               prem_d  = '0;
               state_d = S_CALC;
            end
         end
         S_CALC: begin
            prem_d = prem_ge ? prem_sub : prem_shift;
            mag_d  = {mag_q[DW-2:0], prem_ge};
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            if (dbz_q || fix_sat) begin
               quo_d = neg_q ? Q_MIN : Q_MAX;
               rem_d = '0;
               ovf_d = 1'b1;
            end else begin
               quo_d = fix_quo;
               rem_d = fix_rem;
               ovf_d = 1'b0;
            end
            dbzo_d  = dbz_q;
            state_d = S_DONE;
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers. Reset abandons any operation in flight.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         mag_q   <= '0;
         neg_q   <= 1'b0;
         dvs_q   <= '0;
         dbz_q   <= 1'b0;
         prem_q  <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         ovf_q   <= 1'b0;
         dbzo_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mag_q   <= mag_d;
         neg_q   <= neg_d;
         dvs_q   <= dvs_d;
         dbz_q   <= dbz_d;
         prem_q  <= prem_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         ovf_q   <= ovf_d;
         dbzo_q  <= dbzo_d;
      end
   end

   assign in_ready    = (state_q == S_IDLE);
   assign out_valid   = (state_q == S_DONE);
   assign quotient    = quo_q;
   assign remainder   = rem_q;
   assign overflow    = ovf_q;
   assign div_by_zero = dbzo_q;

endmodule

// File: tb/tb_top_idct_div_sdiv_29s_15ns_16_seq.sv
// Self-checking bench for the sequential IDCT divider. Expected results
// come from an integer reference model and are queued when each
// operation is accepted.
`timescale 1ns/1ps
module tb_top_idct_div_sdiv_29s_15ns_16_seq;

   logic        ap_clk = 1'b0;
   logic        ap_rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [28:0] dividend = '0;
   logic [14:0] divisor = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] quotient;
   logic [15:0] remainder;
   logic        overflow;
   logic        div_by_zero;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [15:0] q;
      logic [15:0] r;
      logic        ovf;
      logic        dbz;
   } exp_t;

   exp_t sb[$];

   top_idct_div_sdiv_29s_15ns_16_seq dut (
      .ap_clk      (ap_clk),
      .ap_rst_n    (ap_rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend    (dividend),
      .divisor     (divisor),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .overflow    (overflow),
      .div_by_zero (div_by_zero)
   );

   always #5 ap_clk = ~ap_clk;

   function automatic exp_t model(input longint d, input longint dv);
      exp_t   e;
      longint q;
      longint r;
      e.ovf = 1'b0;
      e.dbz = 1'b0;
      if (dv == 0) begin
         e.q   = (d < 0) ? 16'h8000 : 16'h7fff;
         e.r   = 16'h0000;
         e.ovf = 1'b1;
         e.dbz = 1'b1;
         return e;
      end
      q = d / dv;
      r = d % dv;
`ifdef TOP_IDCT_DIV_ROUND_NEAREST_EN
      if (2 * ((r < 0) ? -r : r) >= dv) begin
         q = q + ((d < 0) ? -1 : 1);
         r = d - q * dv;
      end
`endif
      if (q > 32767 || q < -32768) begin
         e.q   = (d < 0) ? 16'h8000 : 16'h7fff;
         e.r   = 16'h0000;
         e.ovf = 1'b1;
      end else begin
         e.q = q[15:0];
         e.r = r[15:0];
      end
      return e;
   endfunction

   // Drive one operation, queue its expected result, and wait for out_valid.
   task automatic do_op(input logic [28:0] d, input logic [14:0] dv,
                        output int lat, output logic ir_after);
      int w;
      w = 0;
      while (!in_ready && w < 50) begin
         @(posedge ap_clk); #1;
         w++;
      end
      if (!in_ready) begin
         errors++;
         checks++;
         $display("FAIL accept_timeout in_ready=%0b required 1", in_ready);
      end
      in_valid = 1'b1;
      dividend = d;
      divisor  = dv;
      sb.push_back(model(longint'($signed(d)), longint'(dv)));
      @(posedge ap_clk); #1;
      in_valid = 1'b0;
      ir_after = in_ready;
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge ap_clk); #1;
         lat++;
      end
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      @(posedge ap_clk); #1;
   endtask

   task automatic test_reset();
      ap_rst_n = 1'b0;
      #3;
      checks++;
      if ({in_ready, out_valid, quotient, remainder, overflow, div_by_zero} !== {1'b1, 1'b0, 34'd0}) begin
         errors++;
         $display("FAIL reset_state in_ready=%0b out_valid=%0b q=%0d r=%0d ovf=%0b dbz=%0b required 1 0 0 0 0 0",
                  in_ready, out_valid, quotient, remainder, overflow, div_by_zero);
      end
      #20;
      ap_rst_n = 1'b1;
      @(posedge ap_clk); #1;
   endtask

   task automatic test_basic();
      int   lat;
      logic ir;
      exp_t e;
      out_ready = 1'b1;
      do_op(29'd1000, 15'd10, lat, ir);
      checks++;
      if (ir !== 1'b0) begin
         errors++;
         $display("FAIL basic_in_ready_drop in_ready=%0b required 0", ir);
      end
      checks++;
      if (lat !== 30) begin
         errors++;
         $display("FAIL basic_latency got=%0d required 30", lat);
      end
      checks++;
      if ({quotient, remainder, overflow, div_by_zero} !== {16'd100, 16'd0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL basic_result q=%0d r=%0d ovf=%0b dbz=%0b required 100 0 0 0",
                  $signed(quotient), $signed(remainder), overflow, div_by_zero);
      end
      e = sb.pop_front();
      checks++;
      if ({quotient, remainder, overflow, div_by_zero} !== e) begin
         errors++;
         $display("FAIL basic_scoreboard q=%0d r=%0d required q=%0d r=%0d", $signed(quotient),
                  $signed(remainder), $signed(e.q), $signed(e.r));
      end
      release_result();
   endtask

   task automatic test_truncation();
      int          lat;
      logic        ir;
      exp_t        e;
      logic [15:0] q_req;
      logic [15:0] r_req;
`ifdef TOP_IDCT_DIV_ROUND_NEAREST_EN
      q_req = 16'(-143);
      r_req = 16'd1;
`else
      q_req = 16'(-142);
      r_req = 16'(-6);
`endif
      do_op(29'(-1000), 15'd7, lat, ir);
      checks++;
      if (quotient !== q_req || remainder !== r_req) begin
         errors++;
         $display("FAIL neg_1000_div_7 q=%0d r=%0d required q=%0d r=%0d", $signed(quotient),
                  $signed(remainder), $signed(q_req), $signed(r_req));
      end
      e = sb.pop_front();
      checks++;
      if ({quotient, remainder, overflow, div_by_zero} !== e) begin
         errors++;
         $display("FAIL neg_1000_scoreboard q=%0d r=%0d ovf=%0b required q=%0d r=%0d ovf=%0b",
                  $signed(quotient), $signed(remainder), overflow, $signed(e.q), $signed(e.r), e.ovf);
      end
      release_result();
   endtask

   task automatic test_saturation();
      logic [28:0] dd [6] = '{29'd268435455, 29'h1000_0000, 29'd65534,
                              29'(-65536), 29'd65536, 29'(-65538)};
      logic [14:0] vv [6] = '{15'd1, 15'd1, 15'd2, 15'd2, 15'd2, 15'd2};
      int   lat;
      logic ir;
      exp_t e;
      for (int i = 0; i < 6; i++) begin
         do_op(dd[i], vv[i], lat, ir);
         e = sb.pop_front();
         checks++;
         if ({quotient, remainder, overflow, div_by_zero} !== e) begin
            errors++;
            $display("FAIL saturation_%0d q=%0d r=%0d ovf=%0b required q=%0d r=%0d ovf=%0b", i,
                     $signed(quotient), $signed(remainder), overflow, $signed(e.q), $signed(e.r), e.ovf);
         end
         release_result();
      end
   endtask

   task automatic test_div_zero();
      int   lat;
      logic ir;
      exp_t e;
      do_op(29'(-5), 15'd0, lat, ir);
      checks++;
      if (lat !== 30) begin
         errors++;
         $display("FAIL div_zero_latency got=%0d required 30", lat);
      end
      checks++;
      if ({quotient, remainder, overflow, div_by_zero} !== {16'h8000, 16'd0, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL div_zero_neg q=%0d r=%0d ovf=%0b dbz=%0b required -32768 0 1 1",
                  $signed(quotient), $signed(remainder), overflow, div_by_zero);
      end
      void'(sb.pop_front());
      release_result();
      do_op(29'd7, 15'd0, lat, ir);
      e = sb.pop_front();
      checks++;
      if ({quotient, remainder, overflow, div_by_zero} !== e) begin
         errors++;
         $display("FAIL div_zero_pos q=%0d ovf=%0b dbz=%0b required q=%0d ovf=%0b dbz=%0b",
                  $signed(quotient), overflow, div_by_zero, $signed(e.q), e.ovf, e.dbz);
      end
      release_result();
   endtask

   task automatic test_backpressure();
      int          lat;
      logic        ir;
      exp_t        e;
      logic [33:0] held;
      int          bad;
      out_ready = 1'b0;
      do_op(29'd12345, 15'd67, lat, ir);
      e = sb.pop_front();
      checks++;
      if ({quotient, remainder, overflow, div_by_zero} !== e) begin
         errors++;
         $display("FAIL backpressure_result q=%0d r=%0d required q=%0d r=%0d",
                  $signed(quotient), $signed(remainder), $signed(e.q), $signed(e.r));
      end
      held = {quotient, remainder, overflow, div_by_zero};
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         dividend = 29'd77;
         divisor  = 15'd5;
         @(posedge ap_clk); #1;
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
             {quotient, remainder, overflow, div_by_zero} !== held) begin
            errors++;
            $display("FAIL backpressure_hold_%0d out_valid=%0b in_ready=%0b q=%0d required 1 0 q=%0d",
                     i, out_valid, in_ready, $signed(quotient), $signed(e.q));
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge ap_clk); #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL backpressure_release out_valid=%0b in_ready=%0b required 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_reset_mid();
      int   lat;
      logic ir;
      exp_t e;
      in_valid = 1'b1;
      dividend = 29'd99999;
      divisor  = 15'd13;
      @(posedge ap_clk); #1;
      in_valid = 1'b0;
      repeat (12) @(posedge ap_clk);
      #1;
      ap_rst_n = 1'b0;
      #1;
      checks++;
      if ({in_ready, out_valid, quotient, remainder, overflow, div_by_zero} !== {1'b1, 1'b0, 34'd0}) begin
         errors++;
         $display("FAIL reset_mid in_ready=%0b out_valid=%0b q=%0d r=%0d ovf=%0b dbz=%0b required 1 0 0 0 0 0",
                  in_ready, out_valid, quotient, remainder, overflow, div_by_zero);
      end
      #2;
      ap_rst_n = 1'b1;
      @(posedge ap_clk); #1;
      out_ready = 1'b1;
      do_op(29'd100, 15'd3, lat, ir);
      checks++;
      if (quotient !== 16'd33 || remainder !== 16'd1 || lat !== 30) begin
         errors++;
         $display("FAIL after_reset_100_div_3 q=%0d r=%0d lat=%0d required 33 1 30",
                  $signed(quotient), $signed(remainder), lat);
      end
      e = sb.pop_front();
      checks++;
      if ({quotient, remainder, overflow, div_by_zero} !== e) begin
         errors++;
         $display("FAIL after_reset_scoreboard q=%0d r=%0d required q=%0d r=%0d",
                  $signed(quotient), $signed(remainder), $signed(e.q), $signed(e.r));
      end
      release_result();
   endtask

   task automatic test_back_to_back();
      int          lat;
      logic        ir;
      exp_t        e;
      logic [28:0] d;
      logic [14:0] dv;
      out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         d  = 29'($urandom);
         if (i % 3 == 0) d = 29'($signed(16'($urandom)));
         dv = (i % 2 == 1) ? 15'($urandom_range(1, 300)) : 15'($urandom_range(1, 32767));
         do_op(d, dv, lat, ir);
         e = sb.pop_front();
         checks++;
         if ({quotient, remainder, overflow, div_by_zero} !== e || lat !== 30) begin
            errors++;
            $display("FAIL random_%0d d=%0d dv=%0d q=%0d r=%0d ovf=%0b lat=%0d required q=%0d r=%0d ovf=%0b lat=30",
                     i, $signed(d), dv, $signed(quotient), $signed(remainder), overflow, lat,
                     $signed(e.q), $signed(e.r), e.ovf);
         end
         release_result();
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_truncation();
      test_saturation();
      test_div_zero();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
